// File: rtl/harris_frame_sequencer.sv
// Frame sequencer for the Harris convolution unit: streams N*N pixels in at the unit step rate,
// then forwards the unit's write-out phase as output strobes. HARRIS_SEQ_TIMEOUT_EN adds a watchdog.
module harris_frame_sequencer #(
  parameter int N           = 8,
  parameter int BIT_SIZE    = 6,
  parameter int PIXEL_WIDTH = 8,
  parameter int STEP_DIV    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [PIXEL_WIDTH-1:0]    pix_data,
  output logic                      unit_we,
  output logic [PIXEL_WIDTH-1:0]    unit_data,
  input  logic                      unit_woe,
  input  logic [BIT_SIZE:0]         unit_addr,
  input  logic [PIXEL_WIDTH-1:0]    unit_pixel,
  input  logic                      unit_harris,
  output logic                      out_valid,
  output logic [BIT_SIZE:0]         out_addr,
  output logic [PIXEL_WIDTH-1:0]    out_pixel,
  output logic                      out_harris,
  output logic [2*(BIT_SIZE+1)-1:0] corner_count,
  output logic                      timeout
);
  // state    | meaning
  // IDLE     | waiting for start
  // LOAD     | one pixel per slot into the unit, whole-slot stalls
  // WAIT_OUT | frame written, waiting for the unit's write-out phase
  // DRAIN    | one returned pixel captured per slot while unit_woe holds
  // DONE     | one-clock completion pulse

  localparam int FRAME = N * N;
  localparam int LC_W  = $clog2(FRAME + 1);
  localparam int CC_W  = 2 * (BIT_SIZE + 1);
  localparam logic [1:0]      PH_LAST   = 2'(STEP_DIV - 1);
  localparam logic [LC_W-1:0] FRAME_CNT = LC_W'(FRAME);

  if (STEP_DIV < 1 || STEP_DIV > 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("harris_frame_sequencer: STEP_DIV must be 1..4 and TIMEOUT_CYC positive");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_OUT, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      phase;
  logic [LC_W-1:0] load_cnt;
  logic            slot_end;
  logic            load_hs;
  logic            capture;
  logic            wd_expire;

  assign slot_end = (phase == PH_LAST);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        pix_ready = slot_end && (load_cnt < FRAME_CNT);
        if (slot_end && load_cnt == FRAME_CNT) state_nxt = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        // a woe that arrives on a slot boundary already carries the first pixel
        capture = slot_end && unit_woe && !wd_expire;
        if (wd_expire)     state_nxt = S_DONE;
        else if (unit_woe) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        capture = slot_end && unit_woe;
        if (wd_expire)                  state_nxt = S_DONE;
        else if (slot_end && !unit_woe) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign load_hs = pix_ready && pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      load_cnt     <= '0;
      unit_we      <= 1'b0;
      unit_data    <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_pixel    <= '0;
      out_harris   <= 1'b0;
      corner_count <= '0;
    end else begin
      phase <= slot_end ? 2'd0 : phase + 2'd1;
      // unit_we only changes on slot boundaries so every write spans a full slot
      if (slot_end) unit_we <= load_hs;
      if (load_hs) begin
        unit_data <= pix_data;
        load_cnt  <= load_cnt + LC_W'(1);
      end else if (state == S_IDLE && start) begin
        load_cnt <= '0;
      end
      out_valid <= capture;
      if (capture) begin
        out_addr   <= unit_addr;
        out_pixel  <= unit_pixel;
        out_harris <= unit_harris;
        if (unit_harris && corner_count != '1) corner_count <= corner_count + CC_W'(1);
      end
      if (state == S_IDLE && start) corner_count <= '0;
    end
  end

`ifdef HARRIS_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == S_WAIT_OUT) || (state == S_DRAIN);
  assign wd_expire = wd_active && !capture && (wd_cnt == '0);

  // down-counter reloads on every strobe, so only silent stretches expire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!wd_active || capture) wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)     wd_cnt <= wd_cnt - WD_W'(1);
      if (wd_expire) timeout <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Self-checking bench for harris_frame_sequencer: load/stall/reset sequences plus a
// table-driven drain whose expected strobes go through a scoreboard queue.
module tb_harris_frame_sequencer;
  localparam int N        = 8;
  localparam int BIT_SIZE = 6;
  localparam int PW       = 8;
  localparam int STEP_DIV = 2;
`ifdef HARRIS_SEQ_TIMEOUT_EN
  localparam int TO_CYC   = 100;
`else
  localparam int TO_CYC   = 4096;
`endif
  localparam int FRAME = N * N;
  localparam int AW    = BIT_SIZE + 1;
  localparam int CW    = 2 * AW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, pix_valid = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          busy, done, pix_ready, unit_we;
  logic [PW-1:0] unit_data;
  logic          unit_woe = 1'b0;
  logic [AW-1:0] unit_addr = '0;
  logic [PW-1:0] unit_pixel = '0;
  logic          unit_harris = 1'b0;
  logic          out_valid, out_harris, timeout;
  logic [AW-1:0] out_addr;
  logic [PW-1:0] out_pixel;
  logic [CW-1:0] corner_count;

  always #5 clk = ~clk;

  harris_frame_sequencer #(
    .N(N), .BIT_SIZE(BIT_SIZE), .PIXEL_WIDTH(PW), .STEP_DIV(STEP_DIV), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .unit_we(unit_we), .unit_data(unit_data), .unit_woe(unit_woe),
    .unit_addr(unit_addr), .unit_pixel(unit_pixel), .unit_harris(unit_harris),
    .out_valid(out_valid), .out_addr(out_addr), .out_pixel(out_pixel),
    .out_harris(out_harris), .corner_count(corner_count), .timeout(timeout)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] pixel;
    logic          harris;
    logic [CW-1:0] cc;
  } drain_vec_t;

  typedef struct {
    drain_vec_t  v;
    int unsigned cyc;
  } exp_out_t;

  drain_vec_t    dtab [FRAME];
  exp_out_t      out_q [$];
  logic [PW-1:0] load_q [$];
  int unsigned   hs_cyc [FRAME];
  int            hs_done;

  int errors = 0, checks = 0;
  int unsigned cyc = 0;
  int tb_phase = 0;
  int we_clocks = 0, out_count = 0, done_count = 0;
  int unsigned first_we = 0, last_we = 0;
  bit we_seen = 0;

  always @(posedge clk or posedge rst)
    if (rst) tb_phase <= 0;
    else     tb_phase <= (tb_phase == STEP_DIV - 1) ? 0 : tb_phase + 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  exp_out_t mon_e;
  logic [PW-1:0] mon_px;
  always @(negedge clk) begin
    if (!rst) begin
      if (unit_we) begin
        we_clocks++;
        if (!we_seen) first_we = cyc;
        we_seen = 1;
        last_we = cyc;
        if (tb_phase == 0) begin
          if (load_q.size() == 0) chk("unit_we_unexpected", 1, 0);
          else begin
            mon_px = load_q.pop_front();
            chk("unit_data", unit_data, mon_px);
          end
        end
      end
      if (out_valid) begin
        out_count++;
        if (out_q.size() == 0) chk("out_valid_unexpected", 1, 0);
        else begin
          mon_e = out_q.pop_front();
          chk("out_addr",     out_addr,     mon_e.v.addr);
          chk("out_pixel",    out_pixel,    mon_e.v.pixel);
          chk("out_harris",   out_harris,   mon_e.v.harris);
          chk("corner_count", corner_count, mon_e.v.cc);
          chk("out_latency",  cyc - mon_e.cyc, 1);
        end
      end
      if (done) done_count++;
    end
  end

  // pixels 0..npix-1 with pix_valid held high; stall_at withholds that pixel for 3 slot boundaries
  task automatic load_frame(input int npix, input int stall_at);
    int p = 0;
    int stalls = 0;
    for (int c = 0; c < 600 && p < npix; c++) begin
      @(negedge clk);
      if (p == stall_at && stalls < 3) begin
        pix_valid = 1'b0;
        if (tb_phase == STEP_DIV - 1) stalls++;
      end else begin
        pix_valid = 1'b1;
        pix_data  = PW'(p);
      end
      if (pix_valid && pix_ready) begin
        chk("hs_phase", tb_phase, STEP_DIV - 1);
        load_q.push_back(PW'(p));
        hs_cyc[p] = cyc;
        p++;
      end
    end
    hs_done = p;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int cc_acc, cc_before, done_at, n;
  bit got_done;

  initial begin
    cc_acc = 0;
    for (int i = 0; i < FRAME; i++) begin
      dtab[i].addr   = AW'(i);
      dtab[i].pixel  = PW'(i * 5 + 3);
      dtab[i].harris = (i == 9 || i == 18 || i == 27);
      if (dtab[i].harris) cc_acc++;
      dtab[i].cc = CW'(cc_acc);
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_unit_we", unit_we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_corner_count", corner_count, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // reset after 10 accepted pixels
    pulse_start();
    chk("load_busy", busy, 1);
    load_frame(10, -1);
    chk("partial_handshakes", hs_done, 10);
    for (int i = 1; i < 10; i++) chk("partial_hs_gap", hs_cyc[i] - hs_cyc[i-1], STEP_DIV);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_unit_we", unit_we, 0);
    chk("midload_rst_pix_ready", pix_ready, 0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load_q.delete();
    we_clocks = 0;
    we_seen = 0;

    // full frame, pixel 6 withheld for 3 slots
    pulse_start();
    load_frame(FRAME, 6);
    @(negedge clk);
    pix_valid = 1'b0;
    chk("frame_handshakes", hs_done, FRAME);
    for (int i = 1; i < FRAME; i++)
      chk("hs_gap", hs_cyc[i] - hs_cyc[i-1], (i == 6) ? 4 * STEP_DIV : STEP_DIV);
    repeat (6) @(negedge clk);
    chk("we_clocks", we_clocks, FRAME * STEP_DIV);
    chk("we_stall_clocks", (last_we - first_we + 1) - we_clocks, 3 * STEP_DIV);
    chk("load_q_empty", load_q.size(), 0);
    chk("wait_unit_we", unit_we, 0);
    chk("wait_pix_ready", pix_ready, 0);
    chk("wait_unit_data", unit_data, FRAME - 1);
    repeat (20) @(negedge clk);
    chk("wait_busy", busy, 1);
    chk("wait_no_done", done_count, 0);
    chk("wait_no_strobe", out_count, 0);
    chk("wait_timeout", timeout, 0);

    // drain, start pulsed mid-way
    for (int c = 0; c < STEP_DIV && tb_phase != 0; c++) @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      unit_woe    = 1'b1;
      unit_addr   = dtab[i].addr;
      unit_pixel  = dtab[i].pixel;
      unit_harris = dtab[i].harris;
      for (int k = 0; k < STEP_DIV; k++) begin
        if (k == STEP_DIV - 1) out_q.push_back('{v: dtab[i], cyc: cyc});
        if (i == 30 && k == 0) begin
          cc_before = corner_count;
          start = 1'b1;
        end else if (start) begin
          start = 1'b0;
          chk("drain_start_busy", busy, 1);
          chk("drain_start_cc", corner_count, cc_before);
        end
        @(negedge clk);
      end
    end
    unit_woe    = 1'b0;
    unit_harris = 1'b0;
    got_done = 0;
    done_at = 0;
    for (int c = 1; c <= 10 && !got_done; c++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        done_at = c;
        chk("done_out_valid", out_valid, 0);
      end
    end
    chk("done_seen", got_done, 1);
    chk("done_delay", done_at, STEP_DIV);
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("done_count", done_count, 1);
    chk("strobe_count", out_count, FRAME);
    chk("final_corner_count", corner_count, 3);
    chk("hold_out_addr", out_addr, FRAME - 1);
    chk("hold_out_pixel", out_pixel, dtab[FRAME-1].pixel);
    chk("hold_out_valid", out_valid, 0);
    chk("out_q_empty", out_q.size(), 0);

`ifdef HARRIS_SEQ_TIMEOUT_EN
    pulse_start();
    load_frame(FRAME, -1);
    @(negedge clk);
    pix_valid = 1'b0;
    for (int c = 0; c < 20 && unit_we; c++) @(negedge clk);
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_done_clock", n, TO_CYC + 1);
    chk("timeout_set", timeout, 1);
    repeat (5) @(negedge clk);
    chk("timeout_sticky", timeout, 1);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_strobe", out_count, FRAME);
    #1 rst = 1'b1;
    #1 chk("timeout_cleared", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
